// File: rtl/div_acc_if.sv
// Controller <-> division accelerator bundle: start/operands toward the
// accelerator, injected instruction pairs and results back to the controller.
interface div_acc_if;
  logic             StartDiv102;
  logic [15:0]      Divident;
  logic [15:0]      Divisor;
  logic             Busy;
  logic             SelAccInst101;
  logic [1:0][15:0] InstFromAcc101;
  logic             AccDone;
  logic             DivErr;
  logic [15:0]      Quotient;
  logic [15:0]      Remainder;

  modport master (
    output StartDiv102, Divident, Divisor,
    input  Busy, SelAccInst101, InstFromAcc101, AccDone, DivErr, Quotient, Remainder
  );

  modport slave (
    input  StartDiv102, Divident, Divisor,
    output Busy, SelAccInst101, InstFromAcc101, AccDone, DivErr, Quotient, Remainder
  );
endinterface

// File: rtl/div_acc.sv
// Division accelerator: restoring divider reproducing the software subtraction loop's
// exit state, then four injected A/C pairs. Optional DIV_ACC_FAST_EN skips DIV when dividend < divisor.
module div_acc #(
  parameter int DIV_BITS = 15
) (
  input logic      Clk,
  input logic      Reset,
  div_acc_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DIV, FIX, INJ} state_t;

  state_t state, nextState;

  logic [DIV_BITS-1:0] shiftReg, divisorReg, quoReg;
  logic [DIV_BITS:0]   remReg;
  logic [3:0]          stepCount;
  logic [1:0]          pairIdx;
  logic                dividendNz;
  logic [15:0]         quotientReg, remainderReg;
  logic                divErrReg;

  logic                acceptWindow, startOk, startBad;
  logic [DIV_BITS-1:0] opDivident, opDivisor;
  logic [DIV_BITS:0]   shifted, trial;
  logic                fits;
  logic [15:0]         fixQ, fixR, absR;
  logic [15:0]         instA, instC;
  logic                unusedTopBits;

  assign opDivident = bus.Divident[DIV_BITS-1:0];
  assign opDivisor  = bus.Divisor[DIV_BITS-1:0];
  assign unusedTopBits = ^{bus.Divident[15:DIV_BITS], bus.Divisor[15:DIV_BITS]};

  assign startOk  = bus.StartDiv102 && (opDivisor != '0);
  assign startBad = bus.StartDiv102 && (opDivisor == '0);

  assign shifted = {remReg[DIV_BITS-1:0], shiftReg[DIV_BITS-1]};
  assign fits    = shifted >= {1'b0, divisorReg};
  assign trial   = shifted - {1'b0, divisorReg};

  // Loop exit: an exact nonzero division stops at R==0; otherwise one extra subtraction leaves R negative.
  always_comb begin
    fixQ = {1'b0, quoReg} + 16'd1;
    fixR = remReg - {1'b0, divisorReg};
    if (remReg == '0 && dividendNz) begin
      fixQ = {1'b0, quoReg};
      fixR = 16'd0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) state <= IDLE;
    else        state <= nextState;
  end

  // The final injection cycle doubles as an acceptance slot so back-to-back starts lose no cycle.
  always_comb begin
    nextState    = state;
    acceptWindow = 1'b0;
    case (state)
      IDLE: acceptWindow = 1'b1;
      DIV:  if (stepCount == 4'(DIV_BITS - 1)) nextState = FIX;
      FIX:  nextState = INJ;
      INJ: begin
        if (pairIdx == 2'd3) begin
          nextState    = IDLE;
          acceptWindow = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
    if (acceptWindow && startOk) begin
`ifdef DIV_ACC_FAST_EN
      nextState = (opDivident < opDivisor) ? FIX : DIV;
`else
      nextState = DIV;
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      shiftReg     <= '0;
      divisorReg   <= '0;
      quoReg       <= '0;
      remReg       <= '0;
      stepCount    <= '0;
      pairIdx      <= '0;
      dividendNz   <= 1'b0;
      quotientReg  <= '0;
      remainderReg <= '0;
      divErrReg    <= 1'b0;
    end else begin
      divErrReg <= acceptWindow && startBad;
      case (state)
        DIV: begin
          shiftReg  <= shiftReg << 1;
          remReg    <= fits ? trial : shifted;
          quoReg    <= {quoReg[DIV_BITS-2:0], fits};
          stepCount <= stepCount + 4'd1;
        end
        FIX: begin
          quotientReg  <= fixQ;
          remainderReg <= fixR;
          pairIdx      <= 2'd0;
        end
        INJ: pairIdx <= pairIdx + 2'd1;
        default: ;
      endcase
      if (acceptWindow && startOk) begin
        shiftReg   <= opDivident;
        divisorReg <= opDivisor;
        dividendNz <= (opDivident != '0);
        quoReg     <= '0;
        remReg     <= '0;
        stepCount  <= '0;
`ifdef DIV_ACC_FAST_EN
        if (opDivident < opDivisor) remReg <= {1'b0, opDivident};
`endif
      end
    end
  end

  assign absR = 16'd0 - remainderReg;

  always_comb begin
    instA = 16'd0;
    instC = 16'd0;
    if (state == INJ) begin
      case (pairIdx)
        2'd0: begin instA = quotientReg; instC = 16'hEC10; end
        2'd1: begin instA = 16'h0001;    instC = 16'hE308; end
        2'd2: begin instA = absR;        instC = 16'hECD0; end
        default: begin instA = 16'h0002; instC = 16'hE308; end
      endcase
    end
  end

  assign bus.InstFromAcc101[0] = instA;
  assign bus.InstFromAcc101[1] = instC;
  assign bus.Busy              = (state != IDLE);
  assign bus.SelAccInst101     = (state == INJ);
  assign bus.AccDone           = (state == INJ) && (pairIdx == 2'd3);
  assign bus.DivErr            = divErrReg;
  assign bus.Quotient          = quotientReg;
  assign bus.Remainder         = remainderReg;

endmodule

// File: tb/tb_div_acc.sv
// Scoreboard bench for div_acc: expected injected pairs are queued at each start
// and a negedge monitor pops and compares them whenever the accelerator injects.
module tb_div_acc;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;

  div_acc_if bus ();

  div_acc #(.DIV_BITS(15)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

`ifdef DIV_ACC_FAST_EN
  localparam int FAST_DONE = 5;
`else
  localparam int FAST_DONE = 20;
`endif
  localparam int SLOW_DONE = 20;

  typedef struct {
    logic [15:0] a;
    logic [15:0] c;
    logic        done;
  } pair_t;

  pair_t expQ[$];
  int vectors     = 0;
  int miscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushExpected(input logic [15:0] q, input logic [15:0] r);
    logic [15:0] absR;
    absR = 16'd0 - r;
    expQ.push_back('{a: q,        c: 16'hEC10, done: 1'b0});
    expQ.push_back('{a: 16'h0001, c: 16'hE308, done: 1'b0});
    expQ.push_back('{a: absR,     c: 16'hECD0, done: 1'b0});
    expQ.push_back('{a: 16'h0002, c: 16'hE308, done: 1'b1});
  endtask

  task automatic driveStart(input logic [15:0] dvd, input logic [15:0] dvs);
    bus.StartDiv102 = 1'b1;
    bus.Divident    = dvd;
    bus.Divisor     = dvs;
    @(posedge Clk);
    #1;
    bus.StartDiv102 = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] dvd, input logic [15:0] dvs);
    @(posedge Clk);
    #1;
    driveStart(dvd, dvs);
  endtask

  task automatic waitDone(input int firstCycle, input int doneCycle,
                          input logic [15:0] q, input logic [15:0] r, input string tag);
    int  cyc;
    bit  seen;
    cyc  = firstCycle;
    seen = 1'b0;
    while (!seen && cyc <= 60) begin
      @(negedge Clk);
      if (cyc == 1) checkOutput({tag, "_busyCycle1"}, 32'(bus.Busy), 32'd1);
      if (bus.AccDone) seen = 1'b1;
      else             cyc++;
    end
    checkOutput({tag, "_doneCycle"}, seen ? cyc : 0, doneCycle);
    checkOutput({tag, "_quotient"}, bus.Quotient, q);
    checkOutput({tag, "_remainder"}, bus.Remainder, r);
    checkOutput({tag, "_busyAtDone"}, 32'(bus.Busy), 32'd1);
    @(negedge Clk);
    checkOutput({tag, "_busyAfter"}, 32'(bus.Busy), 32'd0);
  endtask

  task automatic runDivision(input logic [15:0] dvd, input logic [15:0] dvs,
                             input logic [15:0] q, input logic [15:0] r,
                             input int doneCycle, input string tag);
    pushExpected(q, r);
    applyStimulus(dvd, dvs);
    waitDone(1, doneCycle, q, r, tag);
  endtask

  // Monitor: every injected pair must match the queue head; nothing leaks out otherwise.
  initial begin
    pair_t e;
    forever begin
      @(negedge Clk);
      if (bus.SelAccInst101 === 1'b1) begin
        checkOutput("pairQueueNonEmpty", 32'(expQ.size() != 0), 32'd1);
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          checkOutput("pairA", bus.InstFromAcc101[0], e.a);
          checkOutput("pairC", bus.InstFromAcc101[1], e.c);
          checkOutput("pairDone", 32'(bus.AccDone), 32'(e.done));
        end
      end else begin
        checkOutput("idleInst", 32'(bus.InstFromAcc101), 32'd0);
        checkOutput("idleDone", 32'(bus.AccDone), 32'd0);
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.StartDiv102 = 1'b0;
    bus.Divident    = 16'd0;
    bus.Divisor     = 16'd0;
    Reset           = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(negedge Clk);
    checkOutput("rstBusy", 32'(bus.Busy), 32'd0);
    checkOutput("rstSel", 32'(bus.SelAccInst101), 32'd0);
    checkOutput("rstDivErr", 32'(bus.DivErr), 32'd0);
    checkOutput("rstQuotient", bus.Quotient, 32'd0);
    checkOutput("rstRemainder", bus.Remainder, 32'd0);

    runDivision(16'd20000, 16'd10, 16'h07D0, 16'h0000, SLOW_DONE, "d20000by10");
    runDivision(16'd7,     16'd2,  16'h0004, 16'hFFFF, SLOW_DONE, "d7by2");
    runDivision(16'd0,     16'd5,  16'h0001, 16'hFFFB, FAST_DONE, "d0by5");
    runDivision(16'd3,     16'd9,  16'h0001, 16'hFFFA, FAST_DONE, "d3by9");
    runDivision(16'h7FFF,  16'd1,  16'h7FFF, 16'h0000, SLOW_DONE, "dMaxBy1");
    runDivision(16'h800C,  16'h8004, 16'h0003, 16'h0000, SLOW_DONE, "bit15Ignored");

    // Divisor whose low 15 bits are zero is rejected with a single error pulse.
    applyStimulus(16'd100, 16'h8000);
    @(negedge Clk);
    checkOutput("errPulseCycle1", 32'(bus.DivErr), 32'd1);
    checkOutput("errBusy", 32'(bus.Busy), 32'd0);
    checkOutput("errSel", 32'(bus.SelAccInst101), 32'd0);
    @(negedge Clk);
    checkOutput("errPulseCycle2", 32'(bus.DivErr), 32'd0);
    checkOutput("errBusyCycle2", 32'(bus.Busy), 32'd0);
    checkOutput("errQuotientKept", bus.Quotient, 32'h0003);

    // Second start in cycle 8 must be ignored; results belong to 100/7.
    pushExpected(16'h000F, 16'hFFFB);
    applyStimulus(16'd100, 16'd7);
    repeat (7) @(posedge Clk);
    #1;
    driveStart(16'd50, 16'd3);
    waitDone(9, SLOW_DONE, 16'h000F, 16'hFFFB, "ignoredStart");

    // Reset during cycle 18 cuts the injection after two pairs.
    pushExpected(16'h07D0, 16'h0000);
    applyStimulus(16'd20000, 16'd10);
    repeat (17) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(negedge Clk);
    checkOutput("midRstSel", 32'(bus.SelAccInst101), 32'd0);
    checkOutput("midRstInst", 32'(bus.InstFromAcc101), 32'd0);
    checkOutput("midRstBusy", 32'(bus.Busy), 32'd0);
    checkOutput("midRstQuotient", bus.Quotient, 32'd0);
    checkOutput("midRstPairsLeft", expQ.size(), 32'd2);
    expQ.delete();

    runDivision(16'd20000, 16'd10, 16'h07D0, 16'h0000, SLOW_DONE, "afterReset");

    repeat (2) @(negedge Clk);
    checkOutput("queueDrained", expQ.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
